// File: rtl/stage_writeback.sv
// Writeback stage: accepts retired instructions, waits for load data, and drives the register-file write port.
// Optional macro WB_INSTRET_COUNTER_EN adds a 64-bit retired-instruction counter on o_instret_WB.
module stage_writeback #(
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   i_rst_WB,
   input  logic                   i_valid_MEM,
   output logic                   o_ready_WB,
   input  logic                   i_reg_write_MEM,
   input  logic [INDEX_WIDTH-1:0] i_rd_MEM,
   input  logic [1:0]             i_result_src_MEM,
   input  logic [2:0]             i_funct3_MEM,
   input  logic [DATA_WIDTH-1:0]  i_alu_result_MEM,
   input  logic [DATA_WIDTH-1:0]  i_pc_plus4_MEM,
   input  logic                   i_load_rvalid,
   input  logic [DATA_WIDTH-1:0]  i_load_rdata,
   output logic [DATA_WIDTH-1:0]  o_data_WB,
   output logic [INDEX_WIDTH-1:0] o_rd_WB,
   output logic                   o_write_en_WB,
   output logic                   o_retire_WB,
   output logic [63:0]            o_instret_WB
);

   typedef enum logic [1:0] {IDLE, WAIT_LOAD, WRITE} state_t;

   state_t                 state;
   logic                   cap_reg_write;
   logic [INDEX_WIDTH-1:0] cap_rd;
   logic [1:0]             cap_src;
   logic [2:0]             cap_funct3;
   logic [DATA_WIDTH-1:0]  cap_alu;
   logic [DATA_WIDTH-1:0]  cap_pc4;
   logic                   accept;

   assign o_ready_WB = i_rst_WB && (state != WAIT_LOAD);
   assign accept     = i_valid_MEM && o_ready_WB;

   function automatic logic [DATA_WIDTH-1:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                                     input logic [DATA_WIDTH-1:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = w[{off[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  return {{(DATA_WIDTH-8){b[7]}}, b};
         3'b100:  return {{(DATA_WIDTH-8){1'b0}}, b};
         3'b001:  return {{(DATA_WIDTH-16){h[15]}}, h};
         3'b101:  return {{(DATA_WIDTH-16){1'b0}}, h};
         default: return w;
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] select(input logic [1:0] src, input logic [DATA_WIDTH-1:0] alu,
                                                    input logic [DATA_WIDTH-1:0] pc4,
                                                    input logic [DATA_WIDTH-1:0] ld);
      case (src)
         2'b01:   return ld;
         2'b10:   return pc4;
         default: return alu;
      endcase
   endfunction

   // Non-loads write straight from the inputs at the accept edge; loads write from the captured fields.
   always_ff @(posedge clk) begin
      if (!i_rst_WB) begin
         state         <= IDLE;
         o_data_WB     <= '0;
         o_rd_WB       <= '0;
         o_write_en_WB <= 1'b0;
         o_retire_WB   <= 1'b0;
         cap_reg_write <= 1'b0;
         cap_rd        <= '0;
         cap_src       <= '0;
         cap_funct3    <= '0;
         cap_alu       <= '0;
         cap_pc4       <= '0;
      end else begin
         o_retire_WB   <= 1'b0;
         o_write_en_WB <= 1'b0;
         case (state)
            IDLE, WRITE: begin
               if (accept) begin
                  cap_reg_write <= i_reg_write_MEM;
                  cap_rd        <= i_rd_MEM;
                  cap_src       <= i_result_src_MEM;
                  cap_funct3    <= i_funct3_MEM;
                  cap_alu       <= i_alu_result_MEM;
                  cap_pc4       <= i_pc_plus4_MEM;
                  if (i_result_src_MEM == 2'b01) begin
                     state <= WAIT_LOAD;
                  end else begin
                     state         <= WRITE;
                     o_retire_WB   <= 1'b1;
                     o_write_en_WB <= i_reg_write_MEM && (i_rd_MEM != '0);
                     o_rd_WB       <= i_rd_MEM;
                     o_data_WB     <= select(i_result_src_MEM, i_alu_result_MEM, i_pc_plus4_MEM, '0);
                  end
               end else begin
                  state <= IDLE;
               end
            end
            WAIT_LOAD: begin
               if (i_load_rvalid) begin
                  state         <= WRITE;
                  o_retire_WB   <= 1'b1;
                  o_write_en_WB <= cap_reg_write && (cap_rd != '0);
                  o_rd_WB       <= cap_rd;
                  o_data_WB     <= select(cap_src, cap_alu, cap_pc4,
                                          extract(cap_funct3, cap_alu[1:0], i_load_rdata));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WB_INSTRET_COUNTER_EN
   logic [63:0] instret;

   always_ff @(posedge clk) begin
      if (!i_rst_WB)
         instret <= '0;
      else if (o_retire_WB)
         instret <= instret + 64'd1;
   end

   assign o_instret_WB = instret;
`else
   assign o_instret_WB = '0;
`endif

endmodule
